// File: rtl/mem_defines_pkg.sv
// Shared types and constants for the on-chip SDRAM line responder.
// A "line" is eight 16-bit words, word 0 in the most significant slot.
package mem_defines;

  localparam int SDRAM_BURST_LEN = 8;
  localparam int SDRAM_WORD_W    = 16;
  localparam int SDRAM_ADDR_W    = 24;
  localparam int SDRAM_LINE_W    = SDRAM_BURST_LEN * SDRAM_WORD_W;

  typedef logic [SDRAM_ADDR_W-1:0] sdram_addr_t;
  typedef logic [SDRAM_LINE_W-1:0] sdram_8_wd_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_RD_WAIT,
    ST_RD,
    ST_DONE
  } line_state_t;

  // Extract word idx of a line; word 0 sits at the top of the vector.
  function automatic logic [SDRAM_WORD_W-1:0] line_word(input sdram_8_wd_t line,
                                                        input logic [2:0] idx);
    return line[(SDRAM_BURST_LEN - 1 - int'(idx)) * SDRAM_WORD_W +: SDRAM_WORD_W];
  endfunction

endpackage

// File: rtl/line_mem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Contents are deliberately never reset so data survives a controller reset.
module line_mem_ram
  import mem_defines::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [SDRAM_WORD_W-1:0] wdata,
  output logic [SDRAM_WORD_W-1:0] rdata
);

  logic [SDRAM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Write when enabled and always register the addressed word for reading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_line_mem.sv
// On-chip stand-in for the SDRAM controller's line interface.
// Emulates the init window, one-word-per-clock bursts and a CAS-like read delay
// on top of a block RAM, so the memory path runs without an external device.
module sdram_line_mem
  import mem_defines::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int INIT_CYCLES = 200,
  parameter int RD_LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  sdram_addr_t addr,
  input  logic        wr,
  input  logic        rd,
  input  logic        valid,
  input  sdram_8_wd_t data_line_in,
  output sdram_8_wd_t data_line_out,
  output logic        done,
  output logic        sdram_init_done
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam int ACC_W  = SDRAM_LINE_W - SDRAM_WORD_W;

  line_state_t             state;
  logic [INIT_W-1:0]       init_cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [2:0]              word_idx;
  logic [AW-1:0]           base_addr;
  sdram_8_wd_t             line_q;
  logic                    is_read;
  logic [ACC_W-1:0]        line_acc;

  logic                    ram_we;
  logic [AW-1:0]           ram_addr;
  logic [SDRAM_WORD_W-1:0] ram_wdata;
  logic [SDRAM_WORD_W-1:0] ram_rdata;

  // Address bits above the RAM size are intentionally ignored so lines wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[SDRAM_ADDR_W-1:AW];

  // RAM port is driven straight from the FSM so an async reset stops writes at once.
  always_comb begin
    ram_we    = (state == ST_WR);
    ram_addr  = base_addr + AW'(word_idx);
    ram_wdata = line_word(line_q, word_idx);
  end

  line_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Request FSM: init window, accept, burst write or delayed burst read, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      wait_cnt        <= '0;
      word_idx        <= '0;
      base_addr       <= '0;
      line_q          <= '0;
      is_read         <= 1'b0;
      line_acc        <= '0;
      data_line_out   <= '0;
      done            <= 1'b0;
      sdram_init_done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            sdram_init_done <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        ST_IDLE: begin
          if (valid && (wr || rd)) begin
            base_addr <= addr[AW-1:0];
            line_q    <= data_line_in;
            word_idx  <= '0;
            wait_cnt  <= '0;
            is_read   <= !wr;
            state     <= wr ? ST_WR : ST_RD_WAIT;
          end
        end
        ST_WR: begin
          word_idx <= word_idx + 3'd1;
          if (word_idx == 3'd7) begin
            state <= ST_DONE;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == WAIT_W'(RD_LATENCY - 1)) begin
            state <= ST_RD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_RD: begin
          word_idx <= word_idx + 3'd1;
          if (word_idx != 3'd0) begin
            line_acc <= {line_acc[ACC_W-SDRAM_WORD_W-1:0], ram_rdata};
          end
          if (word_idx == 3'd7) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
          if (is_read) begin
            data_line_out <= {line_acc, ram_rdata};
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
